pmu_level_arbiter: RTL and testbench

PMU_LEVEL_ARBITER -- requirements
Module: pmu_level_arbiter

---
 rtl/pmu_pkg.sv | 16 +
 rtl/pmu_rr_arbiter.sv | 39 +++
 rtl/pmu_level_arbiter.sv | 105 ++++++++++
 tb/tb_pmu_level_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU level-change arbiter: FSM encoding and
// default level-code parameters.
package pmu_pkg;

    localparam int             LEVEL_W_DEF     = 3;
    localparam logic [2:0]     MAX_LEVEL_DEF   = 3'b111;
    localparam logic [2:0]     RESET_LEVEL_DEF = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } pmu_state_e;

endpackage

// File: rtl/pmu_rr_arbiter.sv
// Round-robin grant: picks the first set request at or after the pointer,
// wrapping from N_REQ-1 back to 0.
module pmu_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int               w_sum;
    logic [IDX_W-1:0] w_scan;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves a value held, which would infer a latch.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = 0;
        w_scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_scan = IDX_W'(w_sum);
            if (!o_any && i_req[w_scan]) begin
                o_any           = 1'b1;
                o_grant[w_scan] = 1'b1;
                o_idx           = w_scan;
            end
        end
    end

endmodule

// File: rtl/pmu_level_arbiter.sv
// Serialises level-change requests from several requesters onto the single
// change-level port of the power manager, waiting a settle time after each.
module pmu_level_arbiter
    import pmu_pkg::*;
#(
    parameter int                 N_REQ         = 4,
    parameter int                 LEVEL_W       = LEVEL_W_DEF,
    parameter logic [LEVEL_W-1:0] MAX_LEVEL     = LEVEL_W'(MAX_LEVEL_DEF),
    parameter logic [LEVEL_W-1:0] RESET_LEVEL   = LEVEL_W'(RESET_LEVEL_DEF),
    parameter int                 SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*LEVEL_W-1:0] req_level,
    output logic [N_REQ-1:0]         req_ack,
    output logic                     change_level_flag,
    output logic [LEVEL_W-1:0]       change_level,
    output logic [LEVEL_W-1:0]       current_level,
    output logic                     busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    pmu_state_e         r_state;
    pmu_state_e         w_next_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [LEVEL_W-1:0] r_current_level;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [LEVEL_W-1:0] w_req_lvl;
    logic [LEVEL_W-1:0] w_clamped;

    pmu_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_req_lvl = req_level[int'(w_idx)*LEVEL_W +: LEVEL_W];
    assign w_clamped = (w_req_lvl > MAX_LEVEL) ? MAX_LEVEL : w_req_lvl;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = (w_clamped == r_current_level) ? ST_ACK : ST_ISSUE;
                end
            end
            ST_ISSUE:  w_next_state = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK:    w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_grant         <= '0;
            r_current_level <= RESET_LEVEL;
            r_cnt           <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_grant;
                r_ptr   <= (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + IDX_W'(1);
                // The new level is visible during ISSUE, alongside the strobe.
                if (w_clamped != r_current_level) begin
                    r_current_level <= w_clamped;
                end
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign req_ack           = (r_state == ST_ACK) ? r_grant : '0;
    assign change_level_flag = (r_state == ST_ISSUE);
    assign current_level     = r_current_level;
    assign change_level      = r_current_level;
    assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pmu_level_arbiter.sv
// Self-checking bench for pmu_level_arbiter: scoreboard of expected acks,
// popped and compared as each ack pulse appears.
module tb_pmu_level_arbiter;

    localparam int SETTLE = 16;
    localparam int CHG_LAT = SETTLE + 3;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [11:0] req_level;
    logic [3:0]  req_ack;
    logic        change_level_flag;
    logic [2:0]  change_level;
    logic [2:0]  current_level;
    logic        busy;

    typedef struct {
        int         idx;
        logic [2:0] level;
        int         flags;
        int         latency;
        int         start;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   cyc;
    int   flags_since_ack;
    int   last_ack_cyc;
    int   last_flag_cyc;
    logic prev_flag;

    pmu_level_arbiter #(
        .N_REQ         (4),
        .LEVEL_W       (3),
        .MAX_LEVEL     (3'b111),
        .RESET_LEVEL   (3'b101),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_level         (req_level),
        .req_ack           (req_ack),
        .change_level_flag (change_level_flag),
        .change_level      (change_level),
        .current_level     (current_level),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle-by-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        checks = checks + 3;
        if (change_level !== current_level) begin
            failures++;
            $display("FAIL inv_level_eq change_level=%0b current_level=%0b want equal", change_level, current_level);
        end
        if ((req_ack & (req_ack - 4'd1)) !== 4'd0) begin
            failures++;
            $display("FAIL inv_ack_onehot req_ack=%b want at most one bit", req_ack);
        end
        if (change_level_flag === 1'b1 && prev_flag === 1'b1) begin
            failures++;
            $display("FAIL inv_flag_consecutive flag=1 on two consecutive cycles want single-cycle strobe");
        end
        prev_flag = change_level_flag;
    end

    task automatic tick();
        @(negedge clk);
        if (change_level_flag === 1'b1) begin
            flags_since_ack++;
            last_flag_cyc = cyc;
        end
    endtask

    task automatic drive_req(input int idx, input logic [2:0] lvl);
        req_level[idx*3 +: 3] = lvl;
        req_valid[idx]        = 1'b1;
    endtask

    task automatic push_exp(input int idx, input logic [2:0] lvl, input int flags,
                            input int latency, input int start, input int gap);
        exp_t e;
        e.idx = idx; e.level = lvl; e.flags = flags;
        e.latency = latency; e.start = start; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic wait_ack(input string name);
        exp_t       e;
        bit         seen;
        logic [3:0] want_ack;
        seen = 1'b0;
        for (int n = 0; n < 150 && !seen; n++) begin
            tick();
            if (req_ack !== 4'd0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no ack want=ack within 150 cycles", name);
            return;
        end
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected got=req_ack %b want=no ack", name, req_ack);
            return;
        end
        e = q.pop_front();
        want_ack = 4'b0001 << e.idx;
        checks = checks + 4;
        if (req_ack !== want_ack) begin
            failures++;
            $display("FAIL %s_ack_idx got=%b want=%b", name, req_ack, want_ack);
        end
        if (change_level !== e.level) begin
            failures++;
            $display("FAIL %s_level got=%0b want=%0b", name, change_level, e.level);
        end
        if (flags_since_ack !== e.flags) begin
            failures++;
            $display("FAIL %s_flag_count got=%0d want=%0d", name, flags_since_ack, e.flags);
        end
        if (cyc - e.start + 1 !== e.latency) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, cyc - e.start + 1, e.latency);
        end
        if (e.gap > 0) begin
            checks++;
            if (last_flag_cyc - last_ack_cyc !== e.gap) begin
                failures++;
                $display("FAIL %s_flag_gap got=%0d want=%0d", name, last_flag_cyc - last_ack_cyc, e.gap);
            end
        end
        req_valid[e.idx] = 1'b0;
        last_ack_cyc     = cyc;
        flags_since_ack  = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) tick();
        q.delete();
        flags_since_ack = 0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int bad_flag;
        int bad_busy;
        tick();
        #1;
        checks = checks + 4;
        if (change_level !== 3'b101 || current_level !== 3'b101) begin
            failures++;
            $display("FAIL rst_level got=%0b/%0b want=101", change_level, current_level);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b want=0", busy);
        end
        if (req_ack !== 4'd0) begin
            failures++;
            $display("FAIL rst_ack got=%b want=0000", req_ack);
        end
        if (change_level_flag !== 1'b0) begin
            failures++;
            $display("FAIL rst_flag got=%b want=0", change_level_flag);
        end
        tick();
        reset = 1'b1;
        bad_flag = 0;
        bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (change_level_flag !== 1'b0) bad_flag++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks = checks + 3;
        if (bad_flag != 0) begin
            failures++;
            $display("FAIL idle_flag got=%0d flag cycles want=0", bad_flag);
        end
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL idle_busy got=%0d busy cycles want=0", bad_busy);
        end
        if (change_level !== 3'b101) begin
            failures++;
            $display("FAIL idle_level got=%0b want=101", change_level);
        end
        flags_since_ack = 0;
    endtask

    task automatic test_same_level();
        tick();
        drive_req(2, 3'b101);
        push_exp(2, 3'b101, 0, 2, cyc, 0);
        wait_ack("same_level");
    endtask

    task automatic test_single_change();
        tick();
        drive_req(1, 3'b010);
        push_exp(1, 3'b010, 1, CHG_LAT, cyc, 0);
        wait_ack("single_change");
    endtask

    task automatic test_all_four();
        int start;
        apply_reset();
        tick();
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            drive_req(i, 3'(i + 1));
            push_exp(i, 3'(i + 1), 1, CHG_LAT * (i + 1), start, (i > 0) ? 2 : 0);
        end
        for (int i = 0; i < 4; i++) wait_ack($sformatf("all_four_%0d", i));
        checks++;
        if (current_level !== 3'b100) begin
            failures++;
            $display("FAIL all_four_final got=%0b want=100", current_level);
        end
    endtask

    task automatic test_mid_settle();
        int start3;
        tick();
        start3 = cyc;
        drive_req(3, 3'b010);
        push_exp(3, 3'b010, 1, CHG_LAT, start3, 0);
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_settle_busy got=%b want=1", busy);
        end
        drive_req(0, 3'b111);
        push_exp(0, 3'b111, 1, (start3 + CHG_LAT - 1 + CHG_LAT) - cyc + 1, cyc, 2);
        wait_ack("mid_settle_r3");
        wait_ack("mid_settle_r0");
    endtask

    task automatic test_reset_mid_settle();
        int bad_ack;
        tick();
        drive_req(1, 3'b011);
        push_exp(1, 3'b011, 1, CHG_LAT, cyc, 0);
        repeat (8) tick();
        reset = 1'b0;
        #1;
        checks = checks + 2;
        if (change_level !== 3'b101) begin
            failures++;
            $display("FAIL rst_mid_level got=%0b want=101", change_level);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_busy got=%b want=0", busy);
        end
        bad_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (req_ack !== 4'd0) bad_ack++;
        end
        checks++;
        if (bad_ack != 0) begin
            failures++;
            $display("FAIL rst_mid_ack got=%0d ack cycles want=0", bad_ack);
        end
        q.delete();
        flags_since_ack = 0;
        reset = 1'b1;
        push_exp(1, 3'b011, 1, CHG_LAT, cyc, 0);
        wait_ack("rst_mid_reserve");
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        flags_since_ack = 0;
        last_ack_cyc    = 0;
        last_flag_cyc   = 0;
        prev_flag       = 1'b0;
        reset           = 1'b0;
        req_valid       = '0;
        req_level       = '0;

        test_reset();
        test_same_level();
        test_single_change();
        test_all_four();
        test_mid_settle();
        test_reset_mid_settle();
        repeat (3) tick();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
